system_key_debounce: RTL and testbench

Synchronizes and debounces the raw push-button inputs from the board pins and drives the debounced key levels into the key PIO's `in_port`. Each key has its own 2-flop synchronizer and per-key stability counter, so software reading the PIO sees a clean, metastability-free level. An optional press/release pulse output is available for interrupt or edge-capture logic.

---
 rtl/system_key_pkg.sv | 6 +
 rtl/system_key_debounce_chan.sv | 78 +++++++
 rtl/system_key_debounce.sv | 34 +++
 tb/tb_system_key_debounce.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/system_key_pkg.sv
// system_key_pkg: shared per-key debounce state type and default constants
package system_key_pkg;
  typedef enum logic {STABLE, COUNTING} key_db_state_t;
  localparam int KEY_DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int KEY_CNT_W_DEF = 20;
endpackage

// File: rtl/system_key_debounce_chan.sv
// system_key_debounce_chan: one key channel (2-flop sync, stability FSM/counter, optional edge pulses)
// Ports: clk, reset_n (async active-low), key_raw (raw pin), key_db (debounced level),
//        press_pulse / release_pulse (one-cycle pulses, built only with SYSTEM_KEY_DEBOUNCE_EDGE_EN)
module system_key_debounce_chan
  import system_key_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES_DEF,
  parameter int   CNT_W           = KEY_CNT_W_DEF,
  parameter logic RESET_VAL       = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_raw,
  output logic key_db,
  output logic press_pulse,
  output logic release_pulse
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic s1_q, s2_q;
  logic key_db_q, key_db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  key_db_state_t state_q, state_d;
  logic differ, accept;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q     <= RESET_VAL;
      s2_q     <= RESET_VAL;
      key_db_q <= RESET_VAL;
      cnt_q    <= '0;
      state_q  <= STABLE;
    end else begin
      s1_q     <= key_raw;
      s2_q     <= s1_q;
      key_db_q <= key_db_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
    end
  end
  // In STABLE the count is zero, so a single-cycle window (LAST == 0) accepts immediately.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    key_db_d = key_db_q;
    differ   = s2_q != key_db_q;
    accept   = differ && ((state_q == STABLE) ? (LAST == '0) : (cnt_q == LAST));
    if (!differ) begin
      state_d = STABLE;
      cnt_d   = '0;
    end else if (accept) begin
      state_d  = STABLE;
      cnt_d    = '0;
      key_db_d = s2_q;
    end else begin
      state_d = COUNTING;
      cnt_d   = cnt_q + 1'b1;
    end
  end
  assign key_db = key_db_q;
`ifdef SYSTEM_KEY_DEBOUNCE_EDGE_EN
  logic press_q, press_d, release_q, release_d;
  assign press_d   = accept & ~s2_q;
  assign release_d = accept & s2_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
    end
  end
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
`else
  assign press_pulse   = 1'b0;
  assign release_pulse = 1'b0;
`endif
endmodule

// File: rtl/system_key_debounce.sv
// system_key_debounce: synchronize and debounce WIDTH active-low keys for the key PIO in_port
// Ports: clk, reset_n (async active-low), key_raw[WIDTH] (raw pins, 0 = pressed),
//        key_db[WIDTH] (debounced levels), press_pulse/release_pulse[WIDTH]
//        (one-cycle accept pulses when SYSTEM_KEY_DEBOUNCE_EDGE_EN is defined, else tied 0)
module system_key_debounce
  import system_key_pkg::*;
#(
  parameter int               WIDTH           = 2,
  parameter int               DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES_DEF,
  parameter int               CNT_W           = KEY_CNT_W_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL       = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] key_raw,
  output logic [WIDTH-1:0] key_db,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    system_key_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .RESET_VAL      (RESET_VAL[i])
    ) u_chan (
      .clk          (clk),
      .reset_n      (reset_n),
      .key_raw      (key_raw[i]),
      .key_db       (key_db[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i])
    );
  end
endmodule

// File: tb/tb_system_key_debounce.sv
// tb_system_key_debounce: table-driven, scoreboarded bench for system_key_debounce
module tb_system_key_debounce;
  localparam int D = 8;
`ifdef SYSTEM_KEY_DEBOUNCE_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif
  typedef struct {
    logic [1:0] raw;
    int         n;
    logic [1:0] db;
  } vec_t;
  typedef struct {
    logic [1:0] db;
    logic [1:0] pr;
    logic [1:0] rl;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n;
  logic [1:0] key_raw;
  logic [1:0] key_db, press_pulse, release_pulse;
  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  logic [1:0] m1, m2, m_db, m_pr, m_rl;
  int run[2];
  int press_cnt[2], rel_cnt[2];
  bit watch, mixed;
  vec_t tbl[13];
  system_key_debounce #(.WIDTH(2), .DEBOUNCE_CYCLES(D), .CNT_W(4), .RESET_VAL(2'b11)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .key_raw      (key_raw),
    .key_db       (key_db),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m1 = 2'b11; m2 = 2'b11; m_db = 2'b11; m_pr = 2'b00; m_rl = 2'b00;
    run[0] = 0; run[1] = 0;
  endtask
  // Reference: the level seen by the qualifier lags the pin by two samples; a key flips
  // once that delayed level has differed from the held level on D consecutive edges.
  task automatic model_edge();
    logic [1:0] seen;
    seen = m2; m2 = m1; m1 = key_raw;
    m_pr = 2'b00; m_rl = 2'b00;
    for (int k = 0; k < 2; k++) begin
      if (seen[k] != m_db[k]) begin
        run[k]++;
        if (run[k] == D) begin
          m_db[k] = seen[k];
          m_pr[k] = EDGE & ~seen[k];
          m_rl[k] = EDGE & seen[k];
          run[k]  = 0;
        end
      end else run[k] = 0;
    end
  endtask
  task automatic step(input logic [1:0] raw);
    exp_t e;
    key_raw = raw;
    @(posedge clk);
    model_edge();
    exp_q.push_back('{m_db, m_pr, m_rl});
    #1;
    e = exp_q.pop_front();
    chk("sb_key_db", 32'(key_db), 32'(e.db));
    chk("sb_press", 32'(press_pulse), 32'(e.pr));
    chk("sb_release", 32'(release_pulse), 32'(e.rl));
    for (int k = 0; k < 2; k++) begin
      press_cnt[k] += int'(press_pulse[k]);
      rel_cnt[k]   += int'(release_pulse[k]);
    end
    if (watch && (key_db == 2'b01 || key_db == 2'b10 || press_pulse == 2'b01 ||
        press_pulse == 2'b10 || release_pulse == 2'b01 || release_pulse == 2'b10)) mixed = 1'b1;
  endtask
  task automatic latency(input logic [1:0] raw, input int idx, input logic lvl, output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      step(raw);
      if (n == 0 && key_db[idx] == lvl) n = i;
    end
  endtask
  initial begin
    int n;
    tbl[0]  = '{2'b11, 20, 2'b11};
    tbl[1]  = '{2'b10, 7,  2'b11};
    tbl[2]  = '{2'b11, 10, 2'b11};
    tbl[3]  = '{2'b10, 12, 2'b10};
    tbl[4]  = '{2'b11, 12, 2'b11};
    tbl[5]  = '{2'b10, 8,  2'b11};
    tbl[6]  = '{2'b11, 12, 2'b11};
    tbl[7]  = '{2'b01, 5,  2'b11};
    tbl[8]  = '{2'b11, 2,  2'b11};
    tbl[9]  = '{2'b01, 12, 2'b01};
    tbl[10] = '{2'b11, 14, 2'b11};
    tbl[11] = '{2'b00, 30, 2'b00};
    tbl[12] = '{2'b11, 30, 2'b11};
    watch = 1'b0; mixed = 1'b0;
    press_cnt = '{0, 0}; rel_cnt = '{0, 0};
    reset_n = 1'b0;
    key_raw = 2'b00;
    model_reset();
    #23;
    chk("rst_key_db", 32'(key_db), 32'h3);
    chk("rst_press", 32'(press_pulse), 32'h0);
    chk("rst_release", 32'(release_pulse), 32'h0);
    @(negedge clk);
    key_raw = 2'b11;
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) step(2'b11);
    chk("post_rst_no_press", 32'(press_cnt[0] + press_cnt[1]), 32'h0);
    chk("post_rst_no_release", 32'(rel_cnt[0] + rel_cnt[1]), 32'h0);
    latency(2'b10, 0, 1'b0, n);
    chk("press_latency", 32'(n), 32'd10);
    chk("press_key1_held", 32'(key_db[1]), 32'h1);
    chk("press_pulse_once", 32'(press_cnt[0]), EDGE ? 32'd1 : 32'd0);
    latency(2'b11, 0, 1'b1, n);
    chk("release_latency", 32'(n), 32'd10);
    press_cnt = '{0, 0}; rel_cnt = '{0, 0};
    for (int i = 0; i < 13; i++) begin
      watch = (i >= 11);
      for (int c = 0; c < tbl[i].n; c++) step(tbl[i].raw);
      chk($sformatf("seg%0d_key_db", i), 32'(key_db), 32'(tbl[i].db));
    end
    watch = 1'b0;
    chk("simul_together", 32'(mixed), 32'h0);
    chk("press_cnt0", 32'(press_cnt[0]), EDGE ? 32'd3 : 32'd0);
    chk("press_cnt1", 32'(press_cnt[1]), EDGE ? 32'd2 : 32'd0);
    chk("rel_cnt0", 32'(rel_cnt[0]), EDGE ? 32'd3 : 32'd0);
    chk("rel_cnt1", 32'(rel_cnt[1]), EDGE ? 32'd2 : 32'd0);
    for (int i = 0; i < 5; i++) step(2'b10);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_key_db", 32'(key_db), 32'h3);
    chk("midrst_press", 32'(press_pulse), 32'h0);
    chk("midrst_release", 32'(release_pulse), 32'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    press_cnt = '{0, 0}; rel_cnt = '{0, 0};
    latency(2'b10, 0, 1'b0, n);
    chk("midrst_latency", 32'(n), 32'd10);
    chk("midrst_press_once", 32'(press_cnt[0]), EDGE ? 32'd1 : 32'd0);
    chk("midrst_no_release", 32'(rel_cnt[0] + rel_cnt[1]), 32'h0);
    for (int i = 0; i < 12; i++) step(2'b11);
    chk("final_key_db", 32'(key_db), 32'h3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
